task_scheduler: RTL

- PL-side control and sequencing block for the PS/PL shared-memory task mailbox.
- Owns the control-register window at SMEM_BASEADDR+0x1_0000: PL_READY, ENABLED_TASKS, CURRENT_TASK, TV_IN_READY, TV_OUT_READY and STATUS.
- Launches exactly one task engine per PS request, then waits for that engine's done signal or for a watchdog timeout.
- Raises TV_OUT_READY when the result region at +0x800 is valid. Sits between the AXI-lite register bridge and the task engines.

---
 rtl/task_scheduler_if.sv | 21 ++
 rtl/task_scheduler.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/task_scheduler_if.sv
// Register-bridge bus between the AXI-lite register bridge (master) and the
// task_scheduler control-register window (slave). One-cycle read/write
// strobes with a byte offset; read data returns one cycle after the strobe.
interface task_scheduler_if;
    logic        reg_wr;
    logic        reg_rd;
    logic [4:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic        reg_rvalid;

    modport master (
        output reg_wr, reg_rd, reg_addr, reg_wdata,
        input  reg_rdata, reg_rvalid
    );

    modport slave (
        input  reg_wr, reg_rd, reg_addr, reg_wdata,
        output reg_rdata, reg_rvalid
    );
endinterface

// File: rtl/task_scheduler.sv
// task_scheduler: PL-side sequencer for the PS/PL shared-memory task mailbox.
// Owns the control-register window (PL_READY, ENABLED_TASKS, CURRENT_TASK,
// TV_IN_READY, TV_OUT_READY, STATUS), launches one task engine per PS request
// and waits for that engine's done or a watchdog timeout.
// Optional build macro TASK_CYCLE_COUNT_EN adds the read-only CYCLES register
// at offset 0x18 (launch-to-completion cycle count); without it 0x18 reads 0.
module task_scheduler #(
    parameter int unsigned          NUM_TASKS      = 15,
    parameter logic [NUM_TASKS-1:0] ENABLED_MASK   = 15'h0237,
    parameter int unsigned          TIMEOUT_CYCLES = 1000000,
    parameter int unsigned          INIT_CYCLES    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    task_scheduler_if.slave      bus,
    output logic [NUM_TASKS-1:0] task_start,
    input  logic [NUM_TASKS-1:0] task_done,
    output logic                 task_abort,
    output logic                 busy
);

    // Control-window byte offsets.
    localparam logic [4:0] ADDR_PL_READY = 5'h00;
    localparam logic [4:0] ADDR_ENABLED  = 5'h04;
    localparam logic [4:0] ADDR_CURRENT  = 5'h08;
    localparam logic [4:0] ADDR_TV_IN    = 5'h0C;
    localparam logic [4:0] ADDR_TV_OUT   = 5'h10;
    localparam logic [4:0] ADDR_STATUS   = 5'h14;
`ifdef TASK_CYCLE_COUNT_EN
    localparam logic [4:0] ADDR_CYCLES   = 5'h18;
`endif

    // Built-in engine mask widened so any 5-bit task number can index it.
    localparam logic [31:0] MASK_EXT = 32'(ENABLED_MASK);

    // STATUS bit positions.
    localparam int ST_INVALID  = 0;
    localparam int ST_TIMEOUT  = 1;
    localparam int ST_BUSY_WR  = 2;
    localparam int ST_SPURIOUS = 3;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_CHECK,
        S_LAUNCH,
        S_RUN,
        S_DONE
    } state_t;

    state_t               state;
    logic [4:0]           current_task;
    logic                 tv_in_ready;
    logic                 tv_out_ready;
    logic [3:0]           status;
    logic [NUM_TASKS-1:0] run_sel;
    logic [31:0]          init_cnt;
    logic [31:0]          wd_cnt;

    logic                 pl_ready;
    logic                 in_busy;
    logic                 wr_current;
    logic                 wr_tv_in;
    logic                 wr_status;
    logic                 launch_req;
    logic                 task_ok;
    logic [NUM_TASKS-1:0] task_onehot;
    logic                 run_done;
    logic                 wd_fire;
    logic [3:0]           status_set;
    logic [31:0]          read_value;

    // Only the low bits of write data are meaningful in this window.
    logic                 unused_wdata;
    assign unused_wdata = ^bus.reg_wdata[31:5];

    // Decode of bus writes, task validity and completion events for this cycle.
    // NOTE: every always_comb output gets a default first so no path can leave
    // it unassigned and infer a latch.
    always_comb begin
        pl_ready    = (state == S_IDLE) || (state == S_DONE);
        in_busy     = (state == S_LAUNCH) || (state == S_RUN);
        wr_current  = bus.reg_wr && (bus.reg_addr == ADDR_CURRENT);
        // A TV_IN_READY write with bit0=0 is never acted on.
        wr_tv_in    = bus.reg_wr && (bus.reg_addr == ADDR_TV_IN) && bus.reg_wdata[0];
        wr_status   = bus.reg_wr && (bus.reg_addr == ADDR_STATUS);
        launch_req  = wr_tv_in && pl_ready;

        task_ok = 1'b0;
        if ((current_task != 5'd0) && (32'(current_task) <= NUM_TASKS)) begin
            task_ok = MASK_EXT[current_task - 5'd1];
        end
        task_onehot = NUM_TASKS'(1) << (current_task - 5'd1);

        run_done = (state == S_RUN) && (|(task_done & run_sel));
        // Fires on the RUN cycle in which the count reaches the limit.
        wd_fire  = (state == S_RUN) && (TIMEOUT_CYCLES != 0) &&
                   (({1'b0, wd_cnt} + 33'd1) >= 33'(TIMEOUT_CYCLES));

        status_set              = 4'b0000;
        status_set[ST_INVALID]  = (state == S_CHECK) && !task_ok;
        status_set[ST_TIMEOUT]  = wd_fire && !run_done;
        status_set[ST_BUSY_WR]  = in_busy && (wr_current || wr_tv_in);
        status_set[ST_SPURIOUS] = |(task_done & ((state == S_RUN) ? ~run_sel : '1));
    end

    // Sequencer FSM with registered start/abort/busy outputs and the
    // request/result handshake flags.
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_INIT;
            init_cnt     <= '0;
            wd_cnt       <= '0;
            run_sel      <= '0;
            tv_in_ready  <= 1'b0;
            tv_out_ready <= 1'b0;
            task_start   <= '0;
            task_abort   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            task_start <= '0;
            task_abort <= 1'b0;
            case (state)
                S_INIT: begin
                    if ((init_cnt + 32'd1) >= INIT_CYCLES) begin
                        state <= S_IDLE;
                    end else begin
                        init_cnt <= init_cnt + 32'd1;
                    end
                end
                S_IDLE, S_DONE: begin
                    if (launch_req) begin
                        tv_in_ready  <= 1'b1;
                        tv_out_ready <= 1'b0;
                        state        <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    // Latch the engine select so completion matching is immune
                    // to later CURRENT_TASK writes.
                    run_sel <= task_onehot;
                    if (task_ok) begin
                        task_start <= task_onehot;
                        busy       <= 1'b1;
                        state      <= S_LAUNCH;
                    end else begin
                        tv_in_ready  <= 1'b0;
                        tv_out_ready <= 1'b1;
                        state        <= S_DONE;
                    end
                end
                S_LAUNCH: begin
                    wd_cnt <= '0;
                    state  <= S_RUN;
                end
                S_RUN: begin
                    if (run_done || wd_fire) begin
                        // Done wins over a simultaneous timeout: no abort then.
                        task_abort   <= !run_done;
                        busy         <= 1'b0;
                        tv_in_ready  <= 1'b0;
                        tv_out_ready <= 1'b1;
                        state        <= S_DONE;
                    end else if (wd_cnt != '1) begin
                        wd_cnt <= wd_cnt + 32'd1;
                    end
                end
                default: begin
                    state <= S_INIT;
                end
            endcase
        end
    end

    // CURRENT_TASK register; writes are dropped while an engine is launching
    // or running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            current_task <= 5'd0;
        end else if (wr_current && !in_busy) begin
            current_task <= bus.reg_wdata[4:0];
        end
    end

    // STATUS register: write-one-to-clear; an event in the same cycle as the
    // clear keeps its bit set so it is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status <= 4'b0000;
        end else begin
            status <= (status & ~(wr_status ? bus.reg_wdata[3:0] : 4'b0000)) | status_set;
        end
    end

`ifdef TASK_CYCLE_COUNT_EN
    logic [31:0] cycles;

    // Launch-to-completion cycle counter: cleared on the way into LAUNCH,
    // counts LAUNCH and every RUN cycle including the completing one,
    // saturates, and holds afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycles <= '0;
        end else if ((state == S_CHECK) && task_ok) begin
            cycles <= '0;
        end else if (((state == S_LAUNCH) || (state == S_RUN)) && (cycles != '1)) begin
            cycles <= cycles + 32'd1;
        end
    end
`endif

    // Read mux over the pre-write register values; unmapped offsets read 0.
    always_comb begin
        read_value = '0;
        case (bus.reg_addr)
            ADDR_PL_READY: read_value = {31'd0, pl_ready};
            ADDR_ENABLED:  read_value = MASK_EXT;
            ADDR_CURRENT:  read_value = {27'd0, current_task};
            ADDR_TV_IN:    read_value = {31'd0, tv_in_ready};
            ADDR_TV_OUT:   read_value = {31'd0, tv_out_ready};
            ADDR_STATUS:   read_value = {28'd0, status};
`ifdef TASK_CYCLE_COUNT_EN
            ADDR_CYCLES:   read_value = cycles;
`endif
            default:       read_value = '0;
        endcase
    end

    // Registered read response, returned exactly one cycle after the strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.reg_rvalid <= 1'b0;
            bus.reg_rdata  <= '0;
        end else begin
            bus.reg_rvalid <= bus.reg_rd;
            bus.reg_rdata  <= bus.reg_rd ? read_value : '0;
        end
    end

endmodule
